// File: rtl/seq_detect_pkg.sv
// Shared constants for the parameterised serial sequence detector:
// legal pattern-width range, reset pattern and overlap-mode encodings.
package seq_detect_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    localparam logic [3:0] DEFAULT_PAT_C = 4'b1011;

    localparam int OVERLAP_OFF = 0;
    localparam int OVERLAP_ON  = 1;

endpackage : seq_detect_pkg

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Count state: reset/clear win, then increment unless already saturated.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : seq_sat_counter

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a registered Moore match flag.
// Optional saturating match counter compiled in with SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = DEFAULT_PAT_C,
    parameter int               OVERLAP     = OVERLAP_ON,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             z
`ifdef SEQ_DETECT_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_r;
    logic [PAT_W-1:0]  pat_r;
    logic [FILL_W-1:0] fill_r;
    logic              z_r;

    logic              accept_s;
    logic [PAT_W-1:0]  hist_next_s;
    logic [FILL_W-1:0] fill_next_s;
    logic              match_s;

    // Post-shift history/fill and the match decision for an accepted bit.
    always_comb begin
        accept_s    = x_valid & ~pat_load;
        hist_next_s = {hist_r[PAT_W-2:0], x};
        if (fill_r == FILL_FULL) begin
            fill_next_s = FILL_FULL;
        end else begin
            fill_next_s = fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
        end
        match_s = accept_s && (fill_next_s == FILL_FULL) && (hist_next_s == pat_r);
    end

    // Detector state; pat_load outranks x_valid and discards that cycle's bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r <= {PAT_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
            pat_r  <= DEFAULT_PAT;
            z_r    <= 1'b0;
        end else if (pat_load) begin
            pat_r  <= pat_in;
            fill_r <= {FILL_W{1'b0}};
            z_r    <= 1'b0;
        end else if (x_valid) begin
            hist_r <= hist_next_s;
            if (match_s && (OVERLAP == OVERLAP_OFF)) begin
                fill_r <= {FILL_W{1'b0}};
            end else begin
                fill_r <= fill_next_s;
            end
            z_r <= match_s;
        end else begin
            z_r <= 1'b0;
        end
    end

    assign z = z_r;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_s),
        .clear (1'b0),
        .count (match_cnt)
    );
`else
    // No match counter in this build.
`endif

endmodule : seq_detect_param

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: overlapping and non-overlapping instances share
// stimulus and are checked each cycle against a queue-based reference model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       z_a;
    logic       z_b;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
`endif

    logic       sc_reset = 1'b1;
    logic       sc_inc = 1'b0;
    logic       sc_clear = 1'b0;
    logic [1:0] sc_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit         qa[$];
    bit         qb[$];
    logic [3:0] pat_m = 4'b1011;
    bit         ez_a = 1'b0;
    bit         ez_b = 1'b0;
    int         ecnt_a = 0;
    int         ecnt_b = 0;
    int         esc = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .pat_load(pat_load), .pat_in(pat_in), .z(z_a)
`ifdef SEQ_DETECT_MATCH_CNT_EN
        , .match_cnt(cnt_a)
`endif
    );

    seq_detect_param #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .OVERLAP(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .pat_load(pat_load), .pat_in(pat_in), .z(z_b)
`ifdef SEQ_DETECT_MATCH_CNT_EN
        , .match_cnt(cnt_b)
`endif
    );

    seq_sat_counter #(.CNT_W(2)) u_sc (
        .clk(clk), .reset(sc_reset), .inc(sc_inc), .clear(sc_clear), .count(sc_count)
    );

    // Last four accepted bits, first-received bit as MSB.
    function automatic logic [3:0] tail4(input bit q[$]);
        int n = q.size();
        return {q[n-4], q[n-3], q[n-2], q[n-1]};
    endfunction

    task automatic model_step(input bit rst, input bit xv, input bit xb,
                              input bit pl, input logic [3:0] pi);
        if (rst) begin
            qa.delete(); qb.delete();
            pat_m = 4'b1011; ez_a = 1'b0; ez_b = 1'b0; ecnt_a = 0; ecnt_b = 0;
        end else if (pl) begin
            pat_m = pi; qa.delete(); qb.delete(); ez_a = 1'b0; ez_b = 1'b0;
        end else if (xv) begin
            qa.push_back(xb);
            if (qa.size() > 4) void'(qa.pop_front());
            qb.push_back(xb);
            if (qb.size() > 4) void'(qb.pop_front());
            ez_a = (qa.size() == 4) && (tail4(qa) == pat_m);
            ez_b = (qb.size() == 4) && (tail4(qb) == pat_m);
            if (ez_b) qb.delete();
            if (ez_a && ecnt_a < 255) ecnt_a++;
            if (ez_b && ecnt_b < 3) ecnt_b++;
        end else begin
            ez_a = 1'b0; ez_b = 1'b0;
        end
    endtask

    task automatic cycle(input bit rst, input bit xv, input bit xb, input bit pl,
                         input logic [3:0] pi, input string tag);
        reset = rst; x_valid = xv; x = xb; pat_load = pl; pat_in = pi;
        model_step(rst, xv, xb, pl, pi);
        @(posedge clk); #1;
        checks++;
        assert (z_a === ez_a) else begin
            failures++;
            $error("FAIL %s z_ovl: observed=%b expected=%b", tag, z_a, ez_a);
        end
        checks++;
        assert (z_b === ez_b) else begin
            failures++;
            $error("FAIL %s z_novl: observed=%b expected=%b", tag, z_b, ez_b);
        end
`ifdef SEQ_DETECT_MATCH_CNT_EN
        checks++;
        assert (cnt_a === 8'(ecnt_a)) else begin
            failures++;
            $error("FAIL %s cnt_ovl: observed=%0d expected=%0d", tag, cnt_a, ecnt_a);
        end
        checks++;
        assert (cnt_b === 2'(ecnt_b)) else begin
            failures++;
            $error("FAIL %s cnt_novl: observed=%0d expected=%0d", tag, cnt_b, ecnt_b);
        end
`endif
    endtask

    task automatic bit_stream(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b1, bits[i], 1'b0, 4'b0000, tag);
    endtask

    task automatic sc_cycle(input bit rst, input bit inc, input bit clr, input string tag);
        sc_reset = rst; sc_inc = inc; sc_clear = clr;
        if (rst || clr) esc = 0;
        else if (inc && esc < 3) esc++;
        @(posedge clk); #1;
        checks++;
        assert (sc_count === 2'(esc)) else begin
            failures++;
            $error("FAIL %s sat_cnt: observed=%0d expected=%0d", tag, sc_count, esc);
        end
    endtask

    initial begin
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, "reset");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, "reset");

        // 1,0,1,1,0,1,1: overlap hits after bits 4 and 7, non-overlap only after 4
        bit_stream(16'b1011011, 7, "stream1011");

        // All-ones pattern: consecutive matches in overlap mode
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, "load1111");
        bit_stream(16'b11111, 5, "ones");

        // Gap with x_valid low keeps partial history
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, "reset2");
        bit_stream(16'b101, 3, "pregap");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, "gap");
        bit_stream(16'b1, 1, "postgap");

        // Reset mid-sequence discards history and restores default pattern
        bit_stream(16'b101, 3, "premid");
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, "midreset");
        bit_stream(16'b1, 1, "postreset");
        bit_stream(16'b011, 3, "defpat");

        // Many matches: non-overlap counter saturates at 3
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, "load1111b");
        bit_stream(16'hFFFF, 16, "sat");
        bit_stream(16'hFF, 8, "sat2");

        // pat_load with x_valid in same cycle discards the bit
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, "loadprio");
        bit_stream(16'b0111, 4, "afterload");

        // Randomised phase
        for (int i = 0; i < 600; i++) begin
            bit rr, vv, xx, ll;
            logic [3:0] pp;
            rr = ($urandom_range(0, 63) == 0);
            ll = ($urandom_range(0, 15) == 0);
            vv = ($urandom_range(0, 3) != 0);
            xx = 1'($urandom_range(0, 1));
            pp = 4'($urandom_range(0, 15));
            cycle(rr, vv, xx, ll, pp, "random");
        end

        // Stand-alone saturating counter
        sc_cycle(1'b1, 1'b1, 1'b0, "sc_reset");
        for (int i = 0; i < 5; i++) sc_cycle(1'b0, 1'b1, 1'b0, "sc_inc");
        sc_cycle(1'b0, 1'b0, 1'b0, "sc_hold");
        sc_cycle(1'b0, 1'b1, 1'b1, "sc_clear");
        sc_cycle(1'b0, 1'b1, 1'b0, "sc_inc2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_detect_param

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter DEFAULT_PAT, default 4'b1011, pattern value loaded at reset.
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 The block SHALL have parameter CNT_W, default 8, match-counter width.
REQ-005 The block SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port x, input, 1, serial data bit.
REQ-008 The block SHALL have port x_valid, input, 1, x accepted only when high.
REQ-009 The block SHALL have port pat_load, input, 1, strobe to capture pat_in.
REQ-010 The block SHALL have port pat_in, input, PAT_W, new pattern, MSB = first bit received.
REQ-011 The block SHALL have port z, output, 1, registered Moore match flag.
REQ-012 The block SHALL have port match_cnt, output, CNT_W, saturating match count (present only under MATCH_CNT_EN).

Function
REQ-013 The block SHALL keep a history register hist[PAT_W-1:0] and a fill count fill (0..PAT_W) as its state.
REQ-014 On an accepted bit (x_valid=1, pat_load=0), hist SHALL shift left with x entering bit 0, and fill SHALL increment, saturating at PAT_W.
REQ-015 A match SHALL be declared when the post-shift fill equals PAT_W and the post-shift hist equals the pattern register.
REQ-016 z SHALL be registered and rise in the cycle after the clock edge that accepted the final pattern bit (latency 1), with no combinational path from x to z.
REQ-017 z SHALL stay high for exactly one cycle per match, and SHALL show back-to-back highs when consecutive accepted bits each complete a match.
REQ-018 With OVERLAP=1, hist and fill SHALL be retained after a match; with OVERLAP=0, fill SHALL clear to 0 on the match edge.
REQ-019 When x_valid=0, hist, fill and the pattern SHALL hold, and z SHALL be 0 in the following cycle.
REQ-020 On pat_load=1, the pattern register SHALL take pat_in, fill SHALL clear to 0, and z SHALL be 0 next cycle.
REQ-021 pat_load SHALL take priority over x_valid in the same cycle, and that x bit SHALL be discarded.
REQ-022 match_cnt SHALL increment by 1 on each match edge and hold at 2^CNT_W-1 with no wrap.

Reset
REQ-023 While reset=1 at a clk edge: hist=0, fill=0, z=0, match_cnt=0, pattern register=DEFAULT_PAT.
REQ-024 reset SHALL override pat_load and x_valid, and reset mid-sequence SHALL discard all partial history.

Configuration
REQ-025 With macro SEQ_DETECT_MATCH_CNT_EN defined, the match_cnt port and counter SHALL be compiled in per REQ-022.
REQ-026 Without SEQ_DETECT_MATCH_CNT_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Shared package seq_detect_pkg SHALL hold the PAT_W legal range constants, the default pattern constant and the OVERLAP mode encodings.
REQ-028 The counter SHALL be one sub-module, seq_sat_counter (CNT_W-wide, inc/clear, saturating), instantiated only under the macro.

Verification
REQ-029 PAT_W=4, pattern 1011, OVERLAP=1, stream 1,0,1,1,0,1,1 with x_valid=1 -> z=1 in the cycles after bit 4 and bit 7, match_cnt=2.
REQ-030 Same stream with OVERLAP=0 -> z=1 only after bit 4, match_cnt=1.
REQ-031 pat_load with pat_in=4'b1111, then stream 1,1,1,1,1 -> z high for 2 consecutive cycles (after bits 4 and 5).
REQ-032 Stream 1,0,1 then x_valid=0 for 3 cycles then 1 -> z=0 during the gap, z=1 one cycle after the final 1.
REQ-033 Stream 1,0,1, then reset=1 for one cycle, then 1 -> no match, z=0, match_cnt=0, pattern=1011.
REQ-034 CNT_W=2 with 5 matches -> match_cnt saturates at 3, and pat_load with x_valid in the same cycle discards that x bit.
